vscale_dmem_scheduler: RTL



---
 rtl/vscale_dmem_scheduler_pkg.sv | 39 +++
 rtl/vscale_dmem_scheduler_if.sv | 36 +++
 rtl/vscale_rr_pick.sv | 38 +++
 rtl/vscale_dmem_scheduler.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vscale_dmem_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vscale_dmem_scheduler_pkg
// Shared constants and types for the multicore dmem scheduler slice:
//   - default core count / index width and scheduler tuning defaults
//   - HASTI htrans encodings
//   - scheduler state encoding
//   - htrans_is_req(): NONSEQ or SEQ counts as an address-phase request
// No ports (package).
// -----------------------------------------------------------------------------
package vscale_dmem_scheduler_pkg;

  // Multicore defaults.
  localparam int NUM_CORES_DEFAULT      = 4;
  localparam int CORE_IDX_WIDTH_DEFAULT = 2;
  localparam int MAX_HOLD_DEFAULT       = 4;
  localparam int STARVE_LIMIT_DEFAULT   = 32;

  // HASTI bus constants.
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int WAIT_CNT_WIDTH    = 8;

  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,   // no owner active
    SCHED_GRANT = 2'd1,   // owner active, unlocked
    SCHED_LOCK  = 2'd2    // owner held by hmastlock
  } sched_state_e;

  function automatic logic htrans_is_req(input logic [HASTI_TRANS_WIDTH-1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_dmem_scheduler_if.sv
// -----------------------------------------------------------------------------
// vscale_dmem_scheduler_if
// Bundles the signals between the cores / shared dmem port and the scheduler.
//   core_htrans    : per-core dmem htrans, core i in [2i+1:2i]
//   core_hmastlock : per-core dmem hmastlock
//   dmem_hready    : hready of the arbitrated port (high = transfer boundary)
//   next_core      : owner select for the dmem arbiter
//   grant_valid    : current owner has an active request
//   locked         : owner is being held because of hmastlock
//   starve         : per-core starvation flag
// Modports: master = scheduler (drives the select), slave = core/bus side.
// -----------------------------------------------------------------------------
interface vscale_dmem_scheduler_if
  import vscale_dmem_scheduler_pkg::*;
#(
  parameter int NUM_CORES      = NUM_CORES_DEFAULT,
  parameter int CORE_IDX_WIDTH = CORE_IDX_WIDTH_DEFAULT
);
  logic [NUM_CORES*HASTI_TRANS_WIDTH-1:0] core_htrans;
  logic [NUM_CORES-1:0]                   core_hmastlock;
  logic                                   dmem_hready;
  logic [CORE_IDX_WIDTH-1:0]              next_core;
  logic                                   grant_valid;
  logic                                   locked;
  logic [NUM_CORES-1:0]                   starve;

  modport master (
    input  core_htrans, core_hmastlock, dmem_hready,
    output next_core, grant_valid, locked, starve
  );

  modport slave (
    output core_htrans, core_hmastlock, dmem_hready,
    input  next_core, grant_valid, locked, starve
  );
endinterface

// File: rtl/vscale_rr_pick.sv
// -----------------------------------------------------------------------------
// vscale_rr_pick
// Combinational rotating-priority picker: returns the first set bit of req
// found when scanning start, start+1, ... modulo N.
//   req   : request vector
//   start : first index examined (must be < N)
//   found : any request present
//   idx   : index of the chosen request (0 when none)
// -----------------------------------------------------------------------------
module vscale_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  // One extra bit so start+offset can exceed N before the explicit wrap,
  // which keeps non-power-of-two core counts correct.
  logic [W:0] cand;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, start} + (W+1)'(i);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (!found && req[cand[W-1:0]]) begin
        found = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end
endmodule

// File: rtl/vscale_dmem_scheduler.sv
// -----------------------------------------------------------------------------
// vscale_dmem_scheduler
// Round-robin owner select for the shared dmem arbiter. At every transfer
// boundary (dmem_hready=1) it keeps a locked owner, keeps an unlocked owner for
// up to MAX_HOLD consecutive grants, otherwise rotates to the next requester.
// Per-core wait counters raise starve[] once a core has waited STARVE_LIMIT
// cycles.
//   hclk, hresetn : clock, async active-low reset
//   bus (master)  : requests/locks/hready in; next_core, grant_valid,
//                   locked, starve out (all from flops)
// -----------------------------------------------------------------------------
module vscale_dmem_scheduler
  import vscale_dmem_scheduler_pkg::*;
#(
  parameter int NUM_CORES      = NUM_CORES_DEFAULT,
  parameter int CORE_IDX_WIDTH = CORE_IDX_WIDTH_DEFAULT,
  parameter int MAX_HOLD       = MAX_HOLD_DEFAULT,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEFAULT
) (
  input logic                      hclk,
  input logic                      hresetn,
  vscale_dmem_scheduler_if.master  bus
);
  localparam int HOLD_WIDTH = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_WIDTH-1:0]     HOLD_LAST     = HOLD_WIDTH'(MAX_HOLD - 1);
  localparam logic [CORE_IDX_WIDTH-1:0] LAST_CORE     = CORE_IDX_WIDTH'(NUM_CORES - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX      = '1;
  localparam logic [WAIT_CNT_WIDTH-1:0] STARVE_THRESH = WAIT_CNT_WIDTH'(STARVE_LIMIT);

  logic [NUM_CORES-1:0]      req;
  sched_state_e              state_q, state_d;
  logic [CORE_IDX_WIDTH-1:0] owner_q, owner_d;
  logic [HOLD_WIDTH-1:0]     hold_q, hold_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_q [NUM_CORES];
  logic [WAIT_CNT_WIDTH-1:0] wait_d [NUM_CORES];
  logic [NUM_CORES-1:0]      starve_q, starve_d;
  logic [CORE_IDX_WIDTH-1:0] search_start, pick_idx;
  logic                      pick_found;
  logic                      owner_req, owner_lock;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++)
      req[i] = htrans_is_req(bus.core_htrans[HASTI_TRANS_WIDTH*i +: HASTI_TRANS_WIDTH]);
  end

  assign owner_req  = req[owner_q];
  assign owner_lock = bus.core_hmastlock[owner_q];

  // Rotation starts just past the owner, so the owner is examined last.
  assign search_start = (owner_q == LAST_CORE) ? '0 : owner_q + 1'b1;

  vscale_rr_pick #(
    .N (NUM_CORES),
    .W (CORE_IDX_WIDTH)
  ) u_pick (
    .req   (req),
    .start (search_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Ownership decision; everything is frozen between transfer boundaries.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (bus.dmem_hready) begin
      if (owner_req && owner_lock) begin
        state_d = SCHED_LOCK;                 // locked sequences ignore the hold limit
      end else if (owner_req && (hold_q < HOLD_LAST)) begin
        state_d = SCHED_GRANT;
        hold_d  = hold_q + 1'b1;
      end else if (pick_found) begin
        state_d = SCHED_GRANT;                // may re-grant a lone owner
        owner_d = pick_idx;
        hold_d  = '0;
      end else begin
        state_d = SCHED_IDLE;                 // next_core parks on the last owner
      end
    end
  end

  // Wait counters run every cycle, including stalled ones.
  always_comb begin
    starve_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i])
        wait_d[i] = '0;
      else if (bus.dmem_hready && (owner_d == CORE_IDX_WIDTH'(i)))
        wait_d[i] = '0;
      else if ((owner_q != CORE_IDX_WIDTH'(i)) && (wait_q[i] != WAIT_MAX))
        wait_d[i] = wait_q[i] + 1'b1;
      starve_d[i] = (wait_d[i] >= STARVE_THRESH);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= SCHED_IDLE;
      owner_q  <= '0;
      hold_q   <= '0;
      starve_q <= '0;
      // NOTE: the wait-counter array is a handful of flops, not a RAM, so it
      // is reset along with the rest of the state.
      for (int i = 0; i < NUM_CORES; i++) wait_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  assign bus.next_core   = owner_q;
  assign bus.grant_valid = (state_q != SCHED_IDLE);
  assign bus.locked      = (state_q == SCHED_LOCK);
  assign bus.starve      = starve_q;

endmodule
